johnson_phase_decoder: RTL

Downstream consumer of the 8-bit Johnson (twisted-ring) counter stage. Samples the counter word on a valid strobe, checks it is one of the 16 legal Johnson codes, decodes it to a 4-bit phase index, and tracks sequence integrity with a lock state machine. Also counts full revolutions and sequence errors. Results drive the project's dedicated outputs in place of the raw counter word.

---
 rtl/johnson_phase_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/johnson_phase_decoder.sv
// Validates and decodes sampled 8-bit Johnson counter words into a 4-bit phase,
// tracks sequence lock, and counts revolutions and sequence errors.
module johnson_phase_decoder #(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [7:0] code_in,
  input  logic       clear,
  output logic [3:0] phase_out,
  output logic       phase_valid,
  output logic       illegal,
  output logic       locked,
  output logic [7:0] rev_count,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    ACQUIRE,
    CONFIRM,
    LOCKED
  } state_e;

  localparam logic [2:0] LockN = 3'(LOCK_CNT);

  state_e     state_q;
  logic [2:0] match_q;
  logic [3:0] phase_q;
  logic       phase_valid_q;
  logic       illegal_q;
  logic [7:0] rev_q;
  logic [7:0] err_q;

  logic [7:0] inv_code;
  logic [3:0] ones;
  logic       legal;
  logic [3:0] phase_new;
  logic       is_succ;
  logic       is_rep;
  logic       is_wrap;
  logic [2:0] match_d;

  // Legal words are a single run of ones at either end; the first half of the
  // sequence has the run at the MSB (phase = ones), the second at the LSB.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ones = ones + 4'(code_in[i]);
    end
    inv_code  = ~code_in;
    legal     = ((code_in & (code_in + 8'd1)) == 8'h00) ||
                ((inv_code & (inv_code + 8'd1)) == 8'h00);
    phase_new = (code_in[7] || (code_in == 8'h00)) ? ones : 4'(5'd16 - {1'b0, ones});
    is_succ   = (phase_new == phase_q + 4'd1);
    is_rep    = (phase_new == phase_q);
    is_wrap   = (phase_q == 4'd15) && (phase_new == 4'd0);
    match_d   = match_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ACQUIRE;
      match_q       <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      rev_q         <= '0;
      err_q         <= '0;
    end else begin
      phase_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      if (code_valid) begin
        if (!legal) begin
          illegal_q <= 1'b1;
          if (state_q == LOCKED && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
          end
          state_q <= ACQUIRE;
        end else begin
          phase_valid_q <= 1'b1;
          phase_q       <= phase_new;
          case (state_q)
            ACQUIRE: begin
              state_q <= CONFIRM;
              match_q <= '0;
            end
            CONFIRM: begin
              if (is_succ) begin
                match_q <= match_d;
                if (match_d == LockN) state_q <= LOCKED;
              end else if (!is_rep) begin
                match_q <= '0;
              end
            end
            LOCKED: begin
              if (is_succ) begin
                if (is_wrap) rev_q <= rev_q + 8'd1;
              end else if (!is_rep) begin
                if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                state_q <= CONFIRM;
                match_q <= '0;
              end
            end
            default: begin
              state_q <= ACQUIRE;
              match_q <= '0;
            end
          endcase
        end
      end
      // Placed last so a coincident increment loses to clear.
      if (clear) begin
        rev_q <= '0;
        err_q <= '0;
      end
    end
  end

  assign phase_out   = phase_q;
  assign phase_valid = phase_valid_q;
  assign illegal     = illegal_q;
  assign locked      = (state_q == LOCKED);
  assign rev_count   = rev_q;
  assign err_count   = err_q;

endmodule
